am_inserter: RTL and testbench
==============================

# am_inserter

Parametrised alignment-marker inserter for the 40GBASE-R transmit PCS (IEEE 802.3-2022 82.2.7/82.2.8). It sits between the block-distribution stage and the per-lane gearboxes. It carries NUM_LANES 66-bit PCS-lane blocks per beat under a valid/ready handshake, and every AM_PERIOD beats it inserts one alignment marker per lane with that lane's BIP. Upstream sees marker slots as backpressure on `in_ready`, and `am_pending` gives it one beat of advance notice.

## Interface
- NUM_LANES, 4: PCS lanes carried per beat (1..4).
- LANE_BASE, 0: PCS lane number of bus lane 0. Bus lane i uses marker encoding for lane LANE_BASE+i; LANE_BASE+NUM_LANES must be ≤ 4.
- AM_PERIOD, 16384: beats per marker period, including the marker beat. Minimum 2; any integer is legal, not only powers of two.

Ports:
- clk  in  1  clock; the block has one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- am_enable  in  1  1 = insert markers; 0 = pass-through.
- in_data  in  66*NUM_LANES  lane i occupies [66*i +: 66]; bits [1:0] are the sync header.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  beat is accepted when in_valid && in_ready.
- out_data  out  66*NUM_LANES  registered output, same lane layout as in_data.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- am_pending  out  1  the next beat loaded will be a marker.

## Operation
- **Output register.** A single output register holds out_data/out_valid. `load_ok = !out_valid || out_ready`.
- **Beat counter.** blk_cnt is $clog2(AM_PERIOD) bits wide and counts 0..AM_PERIOD-1, wrapping from AM_PERIOD-1 to 0.
- **Marker slot.** `marker_slot = am_enable && blk_cnt == 0`.
- **Marker load.** On load_ok && marker_slot, markers are loaded on all lanes. in_ready is held low and the input is ignored.
- **Data load.** On load_ok && !marker_slot && in_valid, in_data is loaded.
- **Ready/pending.**
  - `in_ready = load_ok && !marker_slot`. This is combinational from out_ready.
  - `am_pending = marker_slot`.
- **Counter advance.** blk_cnt increments on every load (marker or data) while am_enable = 1. It holds when nothing is loaded.
- **Marker format, per lane.** Bits [1:0] = 2'b01. Byte k sits at [2+8k +: 8]. Bytes in order: M0, M1, M2, BIP3, M4, M5, M6, BIP7.
  - BIP3 = the lane's BIP register.
  - BIP7 = ~BIP3.
- **Marker bytes (M0 M1 M2 / M4 M5 M6) by PCS lane.**
  - Lane 0: 90 76 47 / 6F 89 B8.
  - Lane 1: F0 C4 E6 / 0F 3B 19.
  - Lane 2: C5 65 9B / 3A 9A 64.
  - Lane 3: A2 79 3D / 5D 86 C2.
- **BIP fold.** fold(X)[j] = XOR over k=0..7 of X[2+j+8k]. In addition, fold[3] also XORs in X[0], and fold[4] also XORs in X[1].
- **BIP update.** There is one 8-bit BIP register per lane. On each load:
  - marker beat: BIP ← fold(marker as loaded);
  - data beat: BIP ← BIP ^ fold(data).
  - Each marker therefore covers the previous marker plus the AM_PERIOD-1 data blocks after it.
- **am_enable = 0.**
  - No markers are inserted.
  - blk_cnt and every BIP register are forced to 0 each cycle.
  - The first load after am_enable rises is therefore a marker with BIP3 = 00.
- **Change of am_enable.** A change never alters a beat already held in the output register.

## Timing
- **Reset.** Asserting reset_n low takes effect immediately, independent of clk:
  - out_valid = 0, out_data = 0;
  - blk_cnt = 0, all BIP = 0.
- **After reset.** in_ready = 1 if am_enable = 0, else 0 (the first slot is a marker). am_pending = am_enable.
- **Latency.** Accepted input appears on out_data the cycle after acceptance.
- **Throughput.** Sustained throughput with out_ready = 1 is (AM_PERIOD-1)/AM_PERIOD input beats per cycle.
- **Backpressure.** With out_valid = 1 and out_ready = 0, out_data is stable, in_ready = 0, and blk_cnt and BIP are frozen.
- **Simultaneous events.** Output drain and new load in the same cycle is legal; the new beat replaces the old one with no bubble.
- **Reset mid-operation.** A beat held in the output register is discarded. Nothing is replayed.

## Test plan
Bench parameters: NUM_LANES=4, LANE_BASE=0, AM_PERIOD=8, am_enable=1, out_ready=1, in_valid=1, in_data all zero unless stated.
- **First marker after reset.** Release reset. First out beat, lane 0 = {8'hFF, 24'hB8896F, 8'h00, 24'h477690, 2'b01}; lane 3 = {8'hFF, 24'hC2865D, 8'h00, 24'h3D79A2, 2'b01}. in_ready = 0 in the marker slot cycle.
- **Periodicity and BIP chaining.** Markers appear on out beats 0, 8, 16, ... with exactly 7 data beats between them. The beat-8 marker on lane 0 has BIP3 = 08 and BIP7 = F7.
- **BIP over data.** Lane 0 data beat 3 has bits [9:2] = A5, all other bits 0. The next lane-0 marker has BIP3 = AD and BIP7 = 52; the other lanes' BIP3 stays 08.
- **Backpressure.** Hold out_ready = 0 for 5 cycles mid-period. out_data stays stable and in_ready = 0 throughout. The marker still follows exactly 7 data beats, and no input beat is lost or duplicated.
- **Pass-through and re-enable.**
  - With am_enable = 0 for 20 beats, the output equals the input delayed one cycle, with no markers.
  - Raising am_enable makes the next load a marker with BIP3 = 00 and am_pending = 1 in the preceding cycle.
- **Reset mid-operation.** Pull reset_n low asynchronously while out_valid = 1 at blk_cnt = 5. out_valid drops without a clock edge. After release, the first out beat is the reset marker from the first test.

Source files
------------

// File: rtl/am_inserter.sv
// Alignment-marker inserter for a 40GBASE-R transmit PCS.
// Carries NUM_LANES 66-bit blocks per beat and, once every AM_PERIOD beats, replaces the
// beat with one alignment marker per lane carrying that lane's running BIP.
module am_inserter #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned LANE_BASE = 0,
    parameter int unsigned AM_PERIOD = 16384
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      am_enable,
    input  logic [66*NUM_LANES-1:0]   in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [66*NUM_LANES-1:0]   out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      am_pending
);

    localparam int unsigned CntW = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(AM_PERIOD - 1);

    // Even-parity fold of a 66-bit block into the 8 BIP bit positions; the two sync-header
    // bits land on BIP bits 3 and 4.
    function automatic logic [7:0] bip_fold(input logic [65:0] x);
        logic [7:0] f;
        f = '0;
        for (int k = 0; k < 8; k++) begin
            f = f ^ x[2+8*k +: 8];
        end
        f[3] = f[3] ^ x[0];
        f[4] = f[4] ^ x[1];
        return f;
    endfunction

    // Marker block for a PCS lane: {BIP7, M6 M5 M4, BIP3, M2 M1 M0, sync 01}, byte 0 lowest.
    function automatic logic [65:0] marker(input logic [1:0] lane, input logic [7:0] bip);
        logic [23:0] lo;
        logic [23:0] hi;
        case (lane)
            2'd0:    begin lo = 24'h477690; hi = 24'hB8896F; end
            2'd1:    begin lo = 24'hE6C4F0; hi = 24'h193B0F; end
            2'd2:    begin lo = 24'h9B65C5; hi = 24'h649A3A; end
            default: begin lo = 24'h3D79A2; hi = 24'hC2865D; end
        endcase
        return {~bip, hi, bip, lo, 2'b01};
    endfunction

    logic [CntW-1:0]          blk_cnt_d, blk_cnt_q;
    logic [8*NUM_LANES-1:0]   bip_d, bip_q;
    logic [66*NUM_LANES-1:0]  out_data_d, out_data_q;
    logic                     out_valid_d, out_valid_q;
    logic [66*NUM_LANES-1:0]  am_word;
    logic                     load_ok, marker_slot, marker_load, data_load;

    assign load_ok     = !out_valid_q || out_ready;
    assign marker_slot = am_enable && (blk_cnt_q == '0);
    assign marker_load = load_ok && marker_slot;
    assign data_load   = load_ok && !marker_slot && in_valid;

    // Marker slots show up upstream as backpressure, announced one beat ahead by am_pending.
    assign in_ready    = load_ok && !marker_slot;
    assign am_pending  = marker_slot;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;

    // Marker word for every bus lane, stamped with the BIP accumulated since the last marker
    always_comb begin
        am_word = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            am_word[66*i +: 66] = marker(2'(LANE_BASE + i), bip_q[8*i +: 8]);
        end
    end

    // Next state of the output register, the beat counter and the per-lane BIP accumulators
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        blk_cnt_d   = blk_cnt_q;
        bip_d       = bip_q;
        if (marker_load) begin
            out_data_d  = am_word;
            out_valid_d = 1'b1;
            // A marker restarts each BIP from the marker block itself
            for (int i = 0; i < int'(NUM_LANES); i++) begin
                bip_d[8*i +: 8] = bip_fold(am_word[66*i +: 66]);
            end
        end else if (data_load) begin
            out_data_d  = in_data;
            out_valid_d = 1'b1;
            for (int i = 0; i < int'(NUM_LANES); i++) begin
                bip_d[8*i +: 8] = bip_q[8*i +: 8] ^ bip_fold(in_data[66*i +: 66]);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (marker_load || data_load) begin
            blk_cnt_d = (blk_cnt_q == CntMax) ? '0 : blk_cnt_q + CntW'(1);
        end
        // Disabled: hold the period at its start so re-enabling opens with a fresh marker
        if (!am_enable) begin
            blk_cnt_d = '0;
            bip_d     = '0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            blk_cnt_q   <= '0;
            bip_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            blk_cnt_q   <= blk_cnt_d;
            bip_q       <= bip_d;
        end
    end

endmodule

// File: tb/tb_am_inserter.sv
// Self-checking bench for am_inserter: directed steps with random data, compared each cycle
// against a transaction-level model of the marker period and BIP rules.
module tb_am_inserter;

    localparam int NL = 4;
    localparam int LB = 0;
    localparam int AP = 8;
    localparam int W  = 66 * NL;

    localparam logic [65:0] RstMk0 = {8'hFF, 24'hB8896F, 8'h00, 24'h477690, 2'b01};
    localparam logic [65:0] RstMk3 = {8'hFF, 24'hC2865D, 8'h00, 24'h3D79A2, 2'b01};

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         am_enable = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b1;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         am_pending;

    int errors = 0;
    int checks = 0;

    // Reference model state: what the output register should hold and where we are in
    // the marker period (number of beats loaded since the period started).
    logic [W-1:0] m_data;
    logic         m_valid;
    int           m_pos;
    logic [7:0]   m_bip [NL];

    always #5 clk = ~clk;

    am_inserter #(
        .NUM_LANES (NL),
        .LANE_BASE (LB),
        .AM_PERIOD (AP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .am_enable  (am_enable),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .am_pending (am_pending)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] tb_fold(input logic [65:0] x);
        logic [7:0] f;
        f = 8'h00;
        for (int k = 0; k < 8; k++) f = f ^ x[2+8*k +: 8];
        return f ^ {3'b000, x[1], x[0], 3'b000};
    endfunction

    function automatic logic [65:0] tb_marker(input int lane, input logic [7:0] bip);
        logic [47:0] t;
        logic [7:0]  b [8];
        logic [65:0] x;
        case (lane)
            0:       t = 48'h9076476F89B8;
            1:       t = 48'hF0C4E60F3B19;
            2:       t = 48'hC5659B3A9A64;
            default: t = 48'hA2793D5D86C2;
        endcase
        b[0] = t[47:40]; b[1] = t[39:32]; b[2] = t[31:24]; b[3] = bip;
        b[4] = t[23:16]; b[5] = t[15:8];  b[6] = t[7:0];   b[7] = ~bip;
        x = '0;
        x[1:0] = 2'b01;
        for (int k = 0; k < 8; k++) x[2+8*k +: 8] = b[k];
        return x;
    endfunction

    task automatic model_reset();
        m_data  = '0;
        m_valid = 1'b0;
        m_pos   = 0;
        for (int l = 0; l < NL; l++) m_bip[l] = 8'h00;
    endtask

    task automatic rand_data();
        for (int l = 0; l < NL; l++) in_data[66*l +: 66] = 66'({$urandom(), $urandom(), $urandom()});
    endtask

    // One clock: check handshake outputs against the model, advance the model, clock the
    // DUT and compare the output register.
    task automatic step();
        logic slot, can_load;
        logic [65:0] mk;
        #1;
        slot     = am_enable && (m_pos == 0);
        can_load = !m_valid || out_ready;
        check("in_ready", W'(in_ready), W'(can_load && !slot));
        check("am_pending", W'(am_pending), W'(slot));
        if (can_load && slot) begin
            for (int l = 0; l < NL; l++) begin
                mk = tb_marker(LB + l, m_bip[l]);
                m_data[66*l +: 66] = mk;
                m_bip[l] = tb_fold(mk);
            end
            m_valid = 1'b1;
            m_pos   = (m_pos + 1) % AP;
        end else if (can_load && in_valid) begin
            m_data  = in_data;
            m_valid = 1'b1;
            for (int l = 0; l < NL; l++) m_bip[l] = m_bip[l] ^ tb_fold(in_data[66*l +: 66]);
            if (am_enable) m_pos = (m_pos + 1) % AP;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (!am_enable) begin
            m_pos = 0;
            for (int l = 0; l < NL; l++) m_bip[l] = 8'h00;
        end
        @(posedge clk);
        #1;
        check("out_valid", W'(out_valid), W'(m_valid));
        check("out_data", out_data, m_data);
    endtask

    initial begin
        logic [W-1:0] prev_in;
        model_reset();

        // Reset state
        #10;
        check("rst_out_valid", W'(out_valid), W'(1'b0));
        check("rst_out_data", out_data, '0);
        check("rst_in_ready", W'(in_ready), W'(1'b0));
        check("rst_am_pending", W'(am_pending), W'(1'b1));
        #12 reset_n = 1'b1;

        // First marker after reset
        step();
        check("first_mk_lane0", W'(out_data[65:0]), W'(RstMk0));
        check("first_mk_lane3", W'(out_data[66*3 +: 66]), W'(RstMk3));

        // Seven zero data beats then the beat-8 marker with chained BIP
        for (int i = 0; i < AP - 1; i++) step();
        step();
        check("mk8_bip3", W'(out_data[26 +: 8]), W'(8'h08));
        check("mk8_bip7", W'(out_data[58 +: 8]), W'(8'hF7));

        // BIP over data: third data beat carries A5 in lane 0 byte 0
        for (int i = 1; i < AP; i++) begin
            in_data = '0;
            if (i == 3) in_data[9:2] = 8'hA5;
            step();
        end
        in_data = '0;
        step();
        check("mk16_bip3", W'(out_data[26 +: 8]), W'(8'hAD));
        check("mk16_bip7", W'(out_data[58 +: 8]), W'(8'h52));
        for (int l = 1; l < NL; l++) begin
            check("mk16_other_bip3", W'(out_data[66*l + 26 +: 8]), W'(8'h08));
        end

        // Random traffic with random bubbles and stalls
        for (int i = 0; i < 60; i++) begin
            rand_data();
            in_valid  = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 8);
            step();
        end

        // Backpressure mid-period
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && m_pos != 3; i++) begin
            rand_data();
            step();
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2 * AP; i++) begin
            rand_data();
            step();
        end

        // Pass-through, output is the input delayed one cycle
        am_enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rand_data();
            prev_in = in_data;
            step();
            check("passthru", out_data, prev_in);
        end

        // Re-enable: next load is a marker with BIP3 = 00
        am_enable = 1'b1;
        rand_data();
        #1;
        check("reen_pending", W'(am_pending), W'(1'b1));
        step();
        check("reen_bip3", W'(out_data[26 +: 8]), W'(8'h00));
        check("reen_bip7", W'(out_data[58 +: 8]), W'(8'hFF));

        // Reset mid-operation at blk_cnt = 5
        in_data = '0;
        for (int i = 0; i < 2 * AP && m_pos != 5; i++) step();
        check("pre_reset_valid", W'(out_valid), W'(1'b1));
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_valid", W'(out_valid), W'(1'b0));
        check("async_rst_data", out_data, '0);
        model_reset();
        #20 reset_n = 1'b1;
        step();
        check("post_rst_mk_lane0", W'(out_data[65:0]), W'(RstMk0));
        check("post_rst_mk_lane3", W'(out_data[66*3 +: 66]), W'(RstMk3));
        for (int i = 0; i < AP; i++) begin
            rand_data();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
